// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, returns one 32-bit word after WAIT_STATES extra cycles.
// Optional IMEM_WRITE_EN macro adds a word write port (wr_en/wr_addr/wr_data); otherwise the array is read-only.
module imem_responder #(
  parameter int    ADDRESS_BITS = 16,
  parameter int    INDEX_BITS   = 10,
  parameter int    WAIT_STATES  = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRESS_BITS-1:0] req_pc,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDRESS_BITS-1:0] rsp_pc,
  output logic [31:0]             rsp_instr,
  output logic [1:0]              rsp_fault,
`ifdef IMEM_WRITE_EN
  input  logic                    wr_en,
  input  logic [ADDRESS_BITS-1:0] wr_addr,
  input  logic [31:0]             wr_data,
`endif
  output logic [1:0]              dbg_state
);

  localparam int          DEPTH = 2 ** INDEX_BITS;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and response fields hold steady while rsp_valid waits for rsp_ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              wait_cnt;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic [ADDRESS_BITS-1:0] rd_pc;
  logic                    accept;
  logic                    load_rsp;
  logic [1:0]              rd_fault;
  logic [31:0]             rd_word;

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt <= 4'd1) state_nxt = ST_RESP;
      ST_RESP: begin
        if (accept)         state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        else if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    req_ready = !flush && (state == ST_IDLE || (state == ST_RESP && rsp_ready));
    rsp_valid = (state == ST_RESP);
    dbg_state = state;
  end

  assign accept = req_valid && req_ready;

  // With zero wait states the read happens on the accepting edge, so use the live PC.
  assign rd_pc    = accept ? req_pc : pc_q;
  assign load_rsp = (state_nxt == ST_RESP) && (state != ST_RESP || accept);
  assign rd_word  = mem[rd_pc[INDEX_BITS+1:2]];

  always_comb begin
    rd_fault = 2'b00;
    if (rd_pc[1:0] != 2'b00)                 rd_fault = 2'b01;
    else if ((rd_pc >> (INDEX_BITS + 2)) != '0) rd_fault = 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      pc_q      <= '0;
      rsp_pc    <= '0;
      rsp_instr <= NOP;
      rsp_fault <= 2'b00;
    end else begin
      if (accept) begin
        pc_q     <= req_pc;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (load_rsp) begin
        rsp_pc    <= rd_pc;
        rsp_fault <= rd_fault;
        rsp_instr <= (rd_fault != 2'b00) ? NOP : rd_word;
      end
    end
  end

`ifdef IMEM_WRITE_EN
  // Reads above sample the array before this edge's write lands, so same-edge reads see old data.
  always_ff @(posedge clock) begin
    if (wr_en && wr_addr[1:0] == 2'b00 && (wr_addr >> (INDEX_BITS + 2)) == '0)
      mem[wr_addr[INDEX_BITS+1:2]] <= wr_data;
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (defaults: ADDRESS_BITS=16, INDEX_BITS=10, WAIT_STATES=1).
module tb_imem_responder;

  logic        clock = 1'b0;
  logic        reset, flush, req_valid, rsp_ready;
  logic        req_ready, rsp_valid;
  logic [15:0] req_pc, rsp_pc;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault, dbg_state;
`ifdef IMEM_WRITE_EN
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  imem_responder dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pc(rsp_pc),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
`ifdef IMEM_WRITE_EN
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
`ifdef IMEM_WRITE_EN
    wr_en = 1'b1; wr_addr = 16'(idx * 4); wr_data = data;
    step();
    wr_en = 1'b0;
`else
    dut.mem[idx] = data;
`endif
  endtask

  // Issues one request, waits (bounded) for the response, captures it and consumes it.
  task automatic do_req(input logic [15:0] pc, output logic [15:0] p,
                        output logic [31:0] i, output logic [1:0] f);
    int n;
    req_valid = 1'b1; req_pc = pc; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout pc=%h: rsp_valid=%b required 1", pc, rsp_valid);
    end
    p = rsp_pc; i = rsp_instr; f = rsp_fault;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_pc = '0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_instr !== NOP)   begin failures++; $display("FAIL reset_rsp_instr got=%h exp=%h", rsp_instr, NOP); end
    checks++; if (rsp_fault !== 2'b00) begin failures++; $display("FAIL reset_rsp_fault got=%b exp=00", rsp_fault); end
    checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_pc !== 16'h0000) begin failures++; $display("FAIL reset_rsp_pc got=%h exp=0000", rsp_pc); end
  endtask

  task automatic test_basic_read();
    req_valid = 1'b1; req_pc = 16'h0000; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b exp=0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", rsp_valid); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00500093 || rsp_pc !== 16'h0000 || rsp_fault !== 2'b00) begin
        failures++;
        $display("FAIL basic_hold cyc=%0d got v=%b i=%h p=%h f=%b exp v=1 i=00500093 p=0000 f=00",
                 c, rsp_valid, rsp_instr, rsp_pc, rsp_fault);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 16'h0004;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_req_ready got=%b exp=1", req_ready); end
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", rsp_valid); end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_pc !== 16'h0004 || rsp_instr !== 32'h00A00113) begin
      failures++;
      $display("FAIL b2b_rsp got v=%b p=%h i=%h exp v=1 p=0004 i=00a00113", rsp_valid, rsp_pc, rsp_instr);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL b2b_idle got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_faults();
    logic [15:0] p; logic [31:0] i; logic [1:0] f;
    do_req(16'h1236, p, i, f);
    checks++; if (f !== 2'b01 || i !== NOP || p !== 16'h1236) begin failures++; $display("FAIL fault_misaligned got f=%b i=%h p=%h exp f=01 i=%h p=1236", f, i, p, NOP); end
    do_req(16'hFFFC, p, i, f);
    checks++; if (f !== 2'b10 || i !== NOP) begin failures++; $display("FAIL fault_range_top got f=%b i=%h exp f=10 i=%h", f, i, NOP); end
    do_req(16'h1000, p, i, f);
    checks++; if (f !== 2'b10 || i !== NOP) begin failures++; $display("FAIL fault_range_edge got f=%b i=%h exp f=10 i=%h", f, i, NOP); end
    do_req(16'h0FFC, p, i, f);
    checks++; if (f !== 2'b00 || i !== 32'h12345678) begin failures++; $display("FAIL last_word got f=%b i=%h exp f=00 i=12345678", f, i); end
    do_req(16'hFFFE, p, i, f);
    checks++; if (f !== 2'b01 || i !== NOP) begin failures++; $display("FAIL fault_priority got f=%b i=%h exp f=01 i=%h", f, i, NOP); end
    do_req(16'h0008, p, i, f);
    checks++; if (f !== 2'b00 || i !== 32'h40208233) begin failures++; $display("FAIL word2 got f=%b i=%h exp f=00 i=40208233", f, i); end
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_pc = 16'h0008;
    step();
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL flush_wait got v=%b st=%0d exp v=0 st=0", rsp_valid, dbg_state); end
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_no_rsp got=%b exp=0", rsp_valid); end
    flush = 1'b1; req_valid = 1'b1; req_pc = 16'h0004;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_req_ready got=%b exp=0", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL flush_no_accept got st=%0d exp=0", dbg_state); end
    // flush while a response is presented and rsp_ready/req_valid are high
    req_valid = 1'b1; req_pc = 16'h0000;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1;
    step();
    flush = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL flush_resp got v=%b st=%0d exp v=0 st=0", rsp_valid, dbg_state); end
  endtask

  task automatic test_mid_reset();
    req_valid = 1'b1; req_pc = 16'h0004;
    step();
    req_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_instr !== NOP || rsp_pc !== 16'h0000 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got v=%b i=%h p=%h st=%0d exp v=0 i=%h p=0000 st=0", rsp_valid, rsp_instr, rsp_pc, dbg_state, NOP);
    end
  endtask

`ifdef IMEM_WRITE_EN
  task automatic test_write();
    logic [15:0] p; logic [31:0] i; logic [1:0] f;
    wr_en = 1'b1; wr_addr = 16'h0010; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b1; wr_addr = 16'h0012; wr_data = 32'h0BADF00D;
    step();
    wr_en = 1'b0;
    do_req(16'h0010, p, i, f);
    checks++; if (i !== 32'hDEADBEEF || f !== 2'b00) begin failures++; $display("FAIL write_read got i=%h f=%b exp i=deadbeef f=00", i, f); end
  endtask
`endif

  initial begin
    load_word(0, 32'h00500093);
    load_word(1, 32'h00A00113);
    load_word(2, 32'h40208233);
    load_word(1023, 32'h12345678);
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_faults();
    test_flush();
    test_mid_reset();
`ifdef IMEM_WRITE_EN
    test_write();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
